// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: turns the Z match flag into buzzer/LED control with stop, snooze and timeout.
// Optional macro ALARM_AUTO_SNOOZE_EN: an unattended ring timeout snoozes while snoozes remain.
module alarm_ring_ctrl #(
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned SNOOZE_SECS  = 300,
  parameter int unsigned MAX_SNOOZES  = 3
) (
  input  logic       funct_clk,
  input  logic       rst,
  input  logic       Z,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       adjust,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       alarm_led,
  output logic [2:0] snooze_cnt,
  output logic [8:0] secs_left
);

  localparam int unsigned SECS_W = 9;
  localparam int unsigned CNT_W  = 3;

  localparam logic [SECS_W-1:0] RING_LOAD   = SECS_W'(RING_TIMEOUT);
  localparam logic [SECS_W-1:0] SNOOZE_LOAD = SECS_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0]  CNT_LIMIT   = CNT_W'(MAX_SNOOZES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                z_q, z_d;
  logic                z_vld_q, z_vld_d;
  logic                ringing_q, ringing_d;
  logic                alarm_led_q, alarm_led_d;
  logic [CNT_W-1:0]    snooze_cnt_q, snooze_cnt_d;
  logic [SECS_W-1:0]   secs_left_q, secs_left_d;

  logic rise_c;
  logic snooze_ok_c;
  logic expire_c;

  // z_vld_q keeps the first post-reset sample from looking like a rising edge
  assign rise_c      = Z & ~z_q & z_vld_q;
  assign snooze_ok_c = snooze_cnt_q < CNT_LIMIT;
  assign expire_c    = sec_tick & (secs_left_q == SECS_W'(1));

  assign z_d     = Z;
  assign z_vld_d = 1'b1;

  // State and output registers
  always_ff @(posedge funct_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      z_q          <= 1'b0;
      z_vld_q      <= 1'b0;
      ringing_q    <= 1'b0;
      alarm_led_q  <= 1'b0;
      snooze_cnt_q <= '0;
      secs_left_q  <= '0;
    end else begin
      state_q      <= state_d;
      z_q          <= z_d;
      z_vld_q      <= z_vld_d;
      ringing_q    <= ringing_d;
      alarm_led_q  <= alarm_led_d;
      snooze_cnt_q <= snooze_cnt_d;
      secs_left_q  <= secs_left_d;
    end
  end

  // Next-state logic; alarm_en low overrides everything
  always_comb begin
    state_d = state_q;
    if (!alarm_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_c && !adjust) state_d = S_RINGING;
        end
        S_RINGING: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (snooze && snooze_ok_c) begin
            state_d = S_SNOOZE;
          end else if (expire_c) begin
`ifdef ALARM_AUTO_SNOOZE_EN
            state_d = snooze_ok_c ? S_SNOOZE : S_DONE;
`else
            state_d = S_DONE;
`endif
          end
        end
        S_SNOOZE: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (expire_c) begin
            state_d = S_RINGING;
          end
        end
        S_DONE: begin
          if (!Z) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/counter next values, keyed on the state being entered
  always_comb begin
    ringing_d    = 1'b0;
    alarm_led_d  = 1'b0;
    snooze_cnt_d = snooze_cnt_q;
    secs_left_d  = '0;
    case (state_d)
      S_IDLE: begin
        snooze_cnt_d = '0;
      end
      S_RINGING: begin
        ringing_d = 1'b1;
        if (state_q != S_RINGING) begin
          alarm_led_d = 1'b1;
          secs_left_d = RING_LOAD;
          if (state_q == S_IDLE) snooze_cnt_d = '0;
        end else begin
          alarm_led_d = sec_tick ? ~alarm_led_q : alarm_led_q;
          secs_left_d = (sec_tick && secs_left_q != '0) ? secs_left_q - SECS_W'(1)
                                                        : secs_left_q;
        end
      end
      S_SNOOZE: begin
        alarm_led_d = 1'b1;
        if (state_q != S_SNOOZE) begin
          secs_left_d  = SNOOZE_LOAD;
          snooze_cnt_d = (snooze_cnt_q != CNT_MAX) ? snooze_cnt_q + CNT_W'(1)
                                                   : snooze_cnt_q;
        end else begin
          secs_left_d = (sec_tick && secs_left_q != '0) ? secs_left_q - SECS_W'(1)
                                                        : secs_left_q;
        end
      end
      S_DONE: begin
        secs_left_d = '0;
      end
      default: begin
        snooze_cnt_d = '0;
      end
    endcase
  end

  assign ringing    = ringing_q;
  assign alarm_led  = alarm_led_q;
  assign snooze_cnt = snooze_cnt_q;
  assign secs_left  = secs_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed self-checking bench for alarm_ring_ctrl (RING_TIMEOUT=5, SNOOZE_SECS=3, MAX_SNOOZES=2).
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       z;
  logic       sec_tick;
  logic       alarm_en;
  logic       adjust;
  logic       stop;
  logic       snooze;
  logic       ringing;
  logic       alarm_led;
  logic [2:0] snooze_cnt;
  logic [8:0] secs_left;

  int checks = 0;
  int errors = 0;

  alarm_ring_ctrl #(
    .RING_TIMEOUT(5),
    .SNOOZE_SECS (3),
    .MAX_SNOOZES (2)
  ) dut (
    .funct_clk (clk),
    .rst       (rst),
    .Z         (z),
    .sec_tick  (sec_tick),
    .alarm_en  (alarm_en),
    .adjust    (adjust),
    .stop      (stop),
    .snooze    (snooze),
    .ringing   (ringing),
    .alarm_led (alarm_led),
    .snooze_cnt(snooze_cnt),
    .secs_left (secs_left)
  );

  always #5 clk = ~clk;

  // {ringing, alarm_led, snooze_cnt, secs_left}
  function automatic logic [13:0] obs();
    return {ringing, alarm_led, snooze_cnt, secs_left};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One second: three quiet clocks then the strobe, sampled after the strobe edge
  task automatic tick();
    cyc(3);
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; z = 1'b0; sec_tick = 1'b0; alarm_en = 1'b1;
    adjust = 1'b0; stop = 1'b0; snooze = 1'b0;
    cyc(2);
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), 14'h0);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_ring_timeout();
    z = 1'b1;
    cyc(1);
    checks++;
    if (obs() !== {1'b1, 1'b1, 3'd0, 9'd5}) begin
      errors++;
      $display("FAIL ring_entry: got %h expected %h", obs(), {1'b1, 1'b1, 3'd0, 9'd5});
    end
    repeat (4) tick();
    checks++;
    if (obs() !== {1'b1, 1'b1, 3'd0, 9'd1}) begin
      errors++;
      $display("FAIL ring_four_ticks: got %h expected %h", obs(), {1'b1, 1'b1, 3'd0, 9'd1});
    end
    tick();
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL ring_timeout_done: got %h expected %h", obs(), 14'h0);
    end
    cyc(3);
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL done_holds_while_z: got %b expected 0", ringing);
    end
    z = 1'b0;
    cyc(1);
    z = 1'b1;
    cyc(1);
    checks++;
    if (obs() !== {1'b1, 1'b1, 3'd0, 9'd5}) begin
      errors++;
      $display("FAIL retrigger_after_idle: got %h expected %h", obs(), {1'b1, 1'b1, 3'd0, 9'd5});
    end
    tick();
    tick();
    checks++;
    if (secs_left !== 9'd3) begin
      errors++;
      $display("FAIL pre_reset_secs: got %0d expected 3", secs_left);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL async_reset_mid_ring: got %h expected %h", obs(), 14'h0);
    end
    cyc(1);
    rst = 1'b0;
    cyc(3);
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL idle_after_reset_z_high: got %h expected %h", obs(), 14'h0);
    end
  endtask

  task automatic test_inhibit();
    z = 1'b0;
    cyc(1);
    adjust = 1'b1;
    z = 1'b1;
    cyc(2);
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL adjust_blocks: got %b expected 0", ringing);
    end
    z = 1'b0; adjust = 1'b0; alarm_en = 1'b0;
    cyc(1);
    z = 1'b1;
    cyc(2);
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL disabled_blocks: got %b expected 0", ringing);
    end
    alarm_en = 1'b1;
    cyc(3);
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL arm_while_z_high: got %h expected %h", obs(), 14'h0);
    end
  endtask

  task automatic test_snooze();
    z = 1'b0;
    cyc(1);
    z = 1'b1;
    cyc(1);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd1, 9'd3}) begin
      errors++;
      $display("FAIL snooze_entry: got %h expected %h", obs(), {1'b0, 1'b1, 3'd1, 9'd3});
    end
    tick();
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd1, 9'd2}) begin
      errors++;
      $display("FAIL snooze_in_snooze_ignored: got %h expected %h", obs(), {1'b0, 1'b1, 3'd1, 9'd2});
    end
    tick();
    tick();
    checks++;
    if (obs() !== {1'b1, 1'b1, 3'd1, 9'd5}) begin
      errors++;
      $display("FAIL snooze_expire_rering: got %h expected %h", obs(), {1'b1, 1'b1, 3'd1, 9'd5});
    end
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd2, 9'd3}) begin
      errors++;
      $display("FAIL second_snooze: got %h expected %h", obs(), {1'b0, 1'b1, 3'd2, 9'd3});
    end
    repeat (3) tick();
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    checks++;
    if (obs() !== {1'b1, 1'b1, 3'd2, 9'd5}) begin
      errors++;
      $display("FAIL third_snooze_ignored: got %h expected %h", obs(), {1'b1, 1'b1, 3'd2, 9'd5});
    end
    snooze = 1'b1; sec_tick = 1'b1;
    cyc(1);
    snooze = 1'b0; sec_tick = 1'b0;
    checks++;
    if (obs() !== {1'b1, 1'b0, 3'd2, 9'd4}) begin
      errors++;
      $display("FAIL exhausted_snooze_tick_counts: got %h expected %h", obs(), {1'b1, 1'b0, 3'd2, 9'd4});
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b0, 3'd2, 9'd0}) begin
      errors++;
      $display("FAIL stop_to_done: got %h expected %h", obs(), {1'b0, 1'b0, 3'd2, 9'd0});
    end
  endtask

  task automatic test_stop_snooze();
    z = 1'b0;
    cyc(1);
    z = 1'b1;
    cyc(1);
    adjust = 1'b1;
    tick();
    adjust = 1'b0;
    checks++;
    if (obs() !== {1'b1, 1'b0, 3'd0, 9'd4}) begin
      errors++;
      $display("FAIL adjust_after_ring: got %h expected %h", obs(), {1'b1, 1'b0, 3'd0, 9'd4});
    end
    stop = 1'b1; snooze = 1'b1;
    cyc(1);
    stop = 1'b0; snooze = 1'b0;
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL stop_beats_snooze: got %h expected %h", obs(), 14'h0);
    end
    z = 1'b0;
    cyc(1);
    z = 1'b1;
    cyc(1);
    snooze = 1'b1; sec_tick = 1'b1;
    cyc(1);
    snooze = 1'b0; sec_tick = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b1, 3'd1, 9'd3}) begin
      errors++;
      $display("FAIL snooze_beats_tick: got %h expected %h", obs(), {1'b0, 1'b1, 3'd1, 9'd3});
    end
    alarm_en = 1'b0;
    cyc(1);
    checks++;
    if (obs() !== 14'h0) begin
      errors++;
      $display("FAIL disable_in_snooze: got %h expected %h", obs(), 14'h0);
    end
    alarm_en = 1'b1;
    z = 1'b0;
    cyc(1);
  endtask

  task automatic test_timeout_mode();
    logic [13:0] exp_v;
`ifdef ALARM_AUTO_SNOOZE_EN
    exp_v = {1'b0, 1'b1, 3'd1, 9'd3};
`else
    exp_v = 14'h0;
`endif
    z = 1'b1;
    cyc(1);
    repeat (5) tick();
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL timeout_mode: got %h expected %h", obs(), exp_v);
    end
    z = 1'b0;
    alarm_en = 1'b0;
    cyc(1);
    alarm_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_inhibit();
    test_snooze();
    test_stop_snooze();
    test_timeout_mode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Downstream consumer of the time/alarm datapath's Z match flag.
- Decides when the alarm actually sounds, handles stop/snooze buttons, and times out an unattended alarm.
- Drives the buzzer-enable and blinking alarm LED toward the board I/O stage.
- Runs entirely on funct_clk; one-second timing comes from a one-cycle sec_tick strobe.

Parameters:
- RING_TIMEOUT, 60: seconds the alarm rings unattended before auto-stop; legal 1..511.
- SNOOZE_SECS, 300: snooze length in seconds; legal 1..511.
- MAX_SNOOZES, 3: snoozes allowed per alarm event; legal 1..7.

Ports:
- funct_clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Z  in  1  alarm time equals current time (level, high for the whole matching minute).
- sec_tick  in  1  one-cycle pulse once per second, synchronous to funct_clk.
- alarm_en  in  1  alarm armed switch (level).
- adjust  in  1  time-adjust mode active (level).
- stop  in  1  debounced one-cycle pulse.
- snooze  in  1  debounced one-cycle pulse.
- ringing  out  1  buzzer enable.
- alarm_led  out  1  blinks while ringing, steady high while snoozing.
- snooze_cnt  out  3  snoozes used in current event.
- secs_left  out  9  remaining seconds of current ring or snooze window; 0 in IDLE/DONE.

Behaviour:
- Reset values: state=IDLE, ringing=0, alarm_led=0, snooze_cnt=0, secs_left=0, z_q=0.
- All outputs are registered.
- Reset is asynchronous and returns to these values from any state, mid-ring or mid-snooze included.
- Trigger: z_q is Z registered each cycle. rise = Z & ~z_q.
  - Trigger when state=IDLE & rise & alarm_en & ~adjust.
  - ringing goes high on the same edge that first samples Z=1.
  - Arming while Z is already high does not trigger; there is no rising edge.
- States:
  - IDLE → RINGING on trigger. On entry, secs_left=RING_TIMEOUT and snooze_cnt=0.
  - RINGING:
    - stop → DONE.
    - Else snooze & snooze_cnt<MAX_SNOOZES → SNOOZE, snooze_cnt+1, secs_left=SNOOZE_SECS.
    - Snooze with the count exhausted is ignored; the alarm keeps ringing.
    - Each sec_tick decrements secs_left. A sec_tick while secs_left==1 → DONE (timeout; exactly RING_TIMEOUT ticks of ringing).
  - SNOOZE:
    - stop → DONE.
    - Snooze pulses are ignored.
    - Each sec_tick decrements secs_left. A sec_tick at secs_left==1 → RINGING with secs_left=RING_TIMEOUT.
  - DONE: ringing=0. → IDLE when Z==0, which prevents a re-trigger in the same minute. secs_left=0.
- Global overrides:
  - alarm_en==0 forces → IDLE from any state next edge, with outputs cleared.
  - adjust has no effect once ringing has started.
- Priority on the same cycle: alarm_en low > stop > snooze > sec_tick.
- Same-cycle sec_tick and snooze in RINGING: the snooze is taken and the tick is discarded.
- alarm_led:
  - Toggles on each sec_tick in RINGING, starting from 1 on entry.
  - Is 1 in SNOOZE and 0 in IDLE/DONE.
- Counters saturate at 0; they never wrap.

Optional Feature:
- Macro: ALARM_AUTO_SNOOZE_EN.
- Defined: a RINGING timeout with snooze_cnt<MAX_SNOOZES enters SNOOZE, as if snooze had been pressed (count increments). With the count exhausted, timeout → DONE.
- Undefined: timeout always → DONE.

Test Plan:
All scenarios use RING_TIMEOUT=5, SNOOZE_SECS=3, MAX_SNOOZES=2, and sec_tick every 4 clocks.
- Reset asserted mid-RINGING (secs_left=3) → all outputs 0 asynchronously; stays IDLE after release while Z stays high.
- Z 0→1 with alarm_en=1, adjust=0 → ringing=1 and secs_left=5 after that edge. After 5 ticks with no input → ringing=0 in DONE. Z→0 → IDLE.
- Z rises while adjust=1 or alarm_en=0 → ringing stays 0. Setting alarm_en=1 while Z still high → no ring.
- Ringing, snooze pulse → ringing=0, alarm_led=1, snooze_cnt=1, secs_left=3. After 3 ticks → ringing=1, secs_left=5. Second snooze → snooze_cnt=2. Third snooze ignored, ringing stays 1.
- Stop and snooze in the same cycle while RINGING → DONE, snooze_cnt unchanged. alarm_en dropped during SNOOZE → IDLE next edge, snooze_cnt=0.
- ALARM_AUTO_SNOOZE_EN defined, timeout with snooze_cnt=0 → SNOOZE with snooze_cnt=1. Undefined → DONE.
